// File: rtl/mem_port_arbiter.sv
// Shares one single-port block RAM between instruction fetch and data load/store; round-robin on conflict.
// Latency: grant is combinational in the request cycle, read data/valid one cycle after the grant.
// Backpressure: a losing requester holds req and waits; a contested loser is granted the following cycle.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_douta
);

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    owner_t last_owner;
    logic   pend_if;
    logic   pend_d;
    logic   pend_we;

    // On conflict the path that did not own the port last wins.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (if_req && d_req) begin
                if (last_owner == OWN_D) begin
                    if_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else begin
                if_gnt = if_req;
                d_gnt  = d_req;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
    end

    assign mem_din = d_wdata;
    assign mem_wea = d_gnt & d_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_D;
            pend_if    <= 1'b0;
            pend_d     <= 1'b0;
            pend_we    <= 1'b0;
        end else begin
            if (if_gnt) begin
                last_owner <= OWN_IF;
            end else if (d_gnt) begin
                last_owner <= OWN_D;
            end
            pend_if <= if_gnt;
            pend_d  <= d_gnt;
            pend_we <= d_we & d_gnt;
        end
    end

    // Responses in flight when reset rises are dropped in that same cycle.
    assign if_valid = pend_if & ~reset;
    assign d_valid  = pend_d & ~reset;
    assign if_rdata = (pend_if & ~reset) ? mem_douta : '0;
    assign d_rdata  = (pend_d & ~pend_we & ~reset) ? mem_douta : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural block RAM attached.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wea;
    logic [DATA_W-1:0] mem_douta;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea),
        .mem_douta(mem_douta)
    );

    // Block RAM: one-cycle registered read, write on the same edge.
    logic [DATA_W-1:0] ram [1024];
    always @(posedge clk) begin
        if (mem_wea) ram[mem_addr] <= mem_din;
        mem_douta <= ram[mem_addr];
    end

    // Reference state
    logic [DATA_W-1:0] ram_m [1024];
    logic [DATA_W-1:0] if_q[$];
    logic [DATA_W-1:0] d_q[$];
    logic              m_last;
    logic              exp_if_v;
    logic              exp_d_v;
    int                n_chk = 0;
    int                n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Evaluate one cycle at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic              m_ig, m_dg;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        m_ig = !reset && if_req && (!d_req || m_last);
        m_dg = !reset && d_req && (!if_req || !m_last);
        m_addr = m_ig ? if_addr : (m_dg ? d_addr : '0);
        chk("if_gnt", 32'(if_gnt), 32'(m_ig));
        chk("d_gnt", 32'(d_gnt), 32'(m_dg));
        chk("mem_wea", 32'(mem_wea), 32'(m_dg & d_we));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("valid_excl", 32'(if_valid & d_valid), 32'd0);

        chk("if_valid", 32'(if_valid), 32'(exp_if_v && !reset));
        if (exp_if_v && if_q.size() != 0) begin
            e = if_q.pop_front();
            chk("if_rdata", 32'(if_rdata), reset ? 32'd0 : 32'(e));
        end else begin
            chk("if_rdata_idle", 32'(if_rdata), 32'd0);
        end
        chk("d_valid", 32'(d_valid), 32'(exp_d_v && !reset));
        if (exp_d_v && d_q.size() != 0) begin
            e = d_q.pop_front();
            chk("d_rdata", 32'(d_rdata), reset ? 32'd0 : 32'(e));
        end else begin
            chk("d_rdata_idle", 32'(d_rdata), 32'd0);
        end

        if (m_ig) begin
            if_q.push_back(ram_m[if_addr]);
            m_last = 1'b0;
        end
        if (m_dg) begin
            d_q.push_back(d_we ? '0 : ram_m[d_addr]);
            if (d_we) ram_m[d_addr] = d_wdata;
            m_last = 1'b1;
        end
        if (reset) m_last = 1'b1;
        exp_if_v = m_ig;
        exp_d_v  = m_dg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]   = DATA_W'(16'h1000 + i);
            ram_m[i] = DATA_W'(16'h1000 + i);
        end
        m_last = 1'b1; exp_if_v = 1'b0; exp_d_v = 1'b0;
        reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = '0; d_addr = 10'd1; d_wdata = '0;
        #1;

        // Reset with both requests high, then IF wins first conflict
        repeat (3) tick();
        reset = 1'b0;
        tick();
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // Solo fetch, addresses 0..3
        for (int i = 0; i < 4; i++) begin
            if_req = 1'b1; if_addr = ADDR_W'(i);
            tick();
        end
        if_req = 1'b0;
        tick();

        // Store then load to the same address
        d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wdata = 16'hBEEF;
        tick();
        d_we = 1'b0;
        tick();
        d_req = 1'b0;
        tick();

        // Contention: six cycles, both held
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if_addr = ADDR_W'(20 + i); d_addr = ADDR_W'(40 + i);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // Abandoned store: loses to IF, then dropped
        if_req = 1'b1; if_addr = 10'd7; d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 16'h1234;
        tick();
        d_req = 1'b0; if_addr = 10'd8;
        tick();
        if_req = 1'b0; d_we = 1'b0;
        tick();

        // Reset mid-flight
        if_req = 1'b1; if_addr = 10'd3;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; if_req = 1'b0;
        tick();
        tick();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
            d_we = 1'($urandom_range(0, 1));
            if_addr = ADDR_W'($urandom_range(0, 15)); d_addr = ADDR_W'($urandom_range(0, 15));
            d_wdata = DATA_W'($urandom);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
